// File: rtl/zero_cross_pkg.sv
// -----------------------------------------------------------------------------
// zero_cross_pkg
// Shared definitions for the zero-cross synchronised acquisition sequencer and
// the downstream per-cycle blocks that reuse its sample/cycle counter.
//   - default widths for sample data, cycle counters and the timeout counter
//   - sequencer state encoding
//   - minimum accepted samples-per-cycle value
//   - helper deciding when the detector must be enabled
// -----------------------------------------------------------------------------
package zero_cross_pkg;

    localparam int DATA_W_DEF       = 14;
    localparam int CNT_W_DEF        = 16;
    localparam int TO_W_DEF         = 24;
    localparam int CLEAR_CYCLES_DEF = 2;

    // A cycle needs at least two samples for the detector to see a slope.
    localparam int MIN_PTOS = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_LEARN  = 3'd2,
        ST_SEARCH = 3'd3,
        ST_ACQ    = 3'd4,
        ST_DONE   = 3'd5
    } zc_state_e;

    // The detector keeps tracking through the acquisition so that it stays
    // locked; it is only disabled while idle, clearing or finishing.
    function automatic logic det_enabled_in(input zc_state_e s);
        return (s == ST_LEARN) || (s == ST_SEARCH) || (s == ST_ACQ);
    endfunction

endpackage : zero_cross_pkg

// File: rtl/zero_cross_sync_ctrl_counter.sv
// -----------------------------------------------------------------------------
// cycle_sample_counter
// Two-level wrap counter: sample index within a signal cycle and cycle number.
// Ports:
//   clk_i, reset_n_i   clock, asynchronous active-low reset
//   clear_i            load both indices with 0 (has priority over advance_i)
//   advance_i          step to the next sample
//   ptos_i             samples per cycle (>= 2)
//   ncyc_i             number of cycles of the run
//   sample_idx_o       registered sample index
//   cycle_idx_o        registered cycle index
//   terminal_o         current indices are the last sample of the last cycle
// -----------------------------------------------------------------------------
module cycle_sample_counter
    import zero_cross_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             clear_i,
    input  logic             advance_i,
    input  logic [CNT_W-1:0] ptos_i,
    input  logic [CNT_W-1:0] ncyc_i,
    output logic [CNT_W-1:0] sample_idx_o,
    output logic [CNT_W-1:0] cycle_idx_o,
    output logic             terminal_o
);

    logic [CNT_W-1:0] sample_q, sample_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic             last_sample;

    assign last_sample = (sample_q == ptos_i - CNT_W'(1));

    // With ncyc_i = 0 the compare target wraps to all-ones and never matches;
    // the sequencer never runs the counter in that case.
    assign terminal_o = last_sample && (cycle_q == ncyc_i - CNT_W'(1));

    always_comb begin
        sample_d = sample_q;
        cycle_d  = cycle_q;
        if (clear_i) begin
            sample_d = '0;
            cycle_d  = '0;
        end else if (advance_i) begin
            if (last_sample) begin
                sample_d = '0;
                cycle_d  = cycle_q + CNT_W'(1);
            end else begin
                sample_d = sample_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sample_q <= '0;
            cycle_q  <= '0;
        end else begin
            sample_q <= sample_d;
            cycle_q  <= cycle_d;
        end
    end

    assign sample_idx_o = sample_q;
    assign cycle_idx_o  = cycle_q;

endmodule : cycle_sample_counter

// File: rtl/zero_cross_sync_ctrl.sv
// -----------------------------------------------------------------------------
// zero_cross_sync_ctrl
// Sequencer around an external zero-cross detector: clears it, lets it learn
// one period, waits for its positive-slope crossing and then streams N whole
// signal cycles of 1-clock-delayed data with sample/cycle indices.
// Ports:
//   clk_i, reset_n_i        clock, asynchronous active-low reset
//   start_i, abort_i        run request (IDLE only) / return to IDLE
//   ptos_x_ciclo_i          samples per cycle       (latched on start)
//   n_ciclos_i              cycles to acquire       (latched on start)
//   timeout_ptos_i          max samples in SEARCH   (latched on start)
//   data_in_i, zero_cross_i raw sample, detector crossing flag
//   det_reset_n_o, det_enable_o, det_ptos_o   detector control
//   data_out_o, acq_enable_o, sample_idx_o, cycle_idx_o, sync_pulse_o
//                           aligned acquisition stream
//   busy_o, done_o, timeout_err_o, cfg_err_o  status
// All outputs are registered.
// -----------------------------------------------------------------------------
module zero_cross_sync_ctrl
    import zero_cross_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int TO_W         = TO_W_DEF,
    parameter int CLEAR_CYCLES = CLEAR_CYCLES_DEF   // must be >= 1
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [CNT_W-1:0]  ptos_x_ciclo_i,
    input  logic [CNT_W-1:0]  n_ciclos_i,
    input  logic [TO_W-1:0]   timeout_ptos_i,
    input  logic [DATA_W-1:0] data_in_i,
    input  logic              zero_cross_i,
    output logic              det_reset_n_o,
    output logic              det_enable_o,
    output logic [CNT_W-1:0]  det_ptos_o,
    output logic [DATA_W-1:0] data_out_o,
    output logic              acq_enable_o,
    output logic [CNT_W-1:0]  sample_idx_o,
    output logic [CNT_W-1:0]  cycle_idx_o,
    output logic              sync_pulse_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              timeout_err_o,
    output logic              cfg_err_o
);

    zc_state_e         state_q, state_d;
    logic [CNT_W-1:0]  ptos_q, ptos_d;
    logic [CNT_W-1:0]  ncyc_q, ncyc_d;
    logic [TO_W-1:0]   to_lim_q, to_lim_d;
    logic [CNT_W-1:0]  ph_cnt_q, ph_cnt_d;     // CLEAR / LEARN length counter
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;     // samples spent in SEARCH
    logic              det_reset_n_q, det_reset_n_d;
    logic              det_enable_q, det_enable_d;
    logic [DATA_W-1:0] data_out_q;
    logic              acq_enable_q, acq_enable_d;
    logic              sync_pulse_q, sync_pulse_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              timeout_err_q, timeout_err_d;
    logic              cfg_err_q, cfg_err_d;

    logic              cnt_clear, cnt_advance, cnt_terminal;
    logic              cfg_bad;

    assign cfg_bad = (ptos_x_ciclo_i < CNT_W'(MIN_PTOS)) || (timeout_ptos_i == '0);

    always_comb begin
        state_d       = state_q;
        ptos_d        = ptos_q;
        ncyc_d        = ncyc_q;
        to_lim_d      = to_lim_q;
        ph_cnt_d      = ph_cnt_q;
        to_cnt_d      = to_cnt_q;
        timeout_err_d = timeout_err_q;
        acq_enable_d  = 1'b0;
        sync_pulse_d  = 1'b0;
        cfg_err_d     = 1'b0;
        cnt_clear     = 1'b0;
        cnt_advance   = 1'b0;

        if (abort_i) begin
            // Abort wins over start, crossing and timeout in the same clock.
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        if (cfg_bad) begin
                            cfg_err_d = 1'b1;
                        end else begin
                            ptos_d        = ptos_x_ciclo_i;
                            ncyc_d        = n_ciclos_i;
                            to_lim_d      = timeout_ptos_i;
                            timeout_err_d = 1'b0;
                            ph_cnt_d      = '0;
                            state_d       = ST_CLEAR;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (ph_cnt_q == CNT_W'(CLEAR_CYCLES - 1)) begin
                        ph_cnt_d = '0;
                        state_d  = ST_LEARN;
                    end else begin
                        ph_cnt_d = ph_cnt_q + CNT_W'(1);
                    end
                end
                ST_LEARN: begin
                    if (ph_cnt_q == ptos_q - CNT_W'(1)) begin
                        to_cnt_d = '0;
                        state_d  = ST_SEARCH;
                    end else begin
                        ph_cnt_d = ph_cnt_q + CNT_W'(1);
                    end
                end
                ST_SEARCH: begin
                    if (zero_cross_i) begin
                        // The crossing sample is on data_in_i now and appears on
                        // data_out_o next clock as sample 0 of cycle 0.
                        if (ncyc_q == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            cnt_clear    = 1'b1;
                            acq_enable_d = 1'b1;
                            sync_pulse_d = 1'b1;
                            state_d      = ST_ACQ;
                        end
                    end else if (to_cnt_q + TO_W'(1) == to_lim_q) begin
                        timeout_err_d = 1'b1;
                        state_d       = ST_IDLE;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
                ST_ACQ: begin
                    // The indices on the outputs describe the sample being
                    // shown; after the very last one the window closes.
                    if (cnt_terminal) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_advance  = 1'b1;
                        acq_enable_d = 1'b1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Registered Moore-style outputs follow the state being entered.
        det_reset_n_d = (state_d != ST_CLEAR);
        det_enable_d  = det_enabled_in(state_d);
        busy_d        = (state_d != ST_IDLE);
        done_d        = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= ST_IDLE;
            ptos_q        <= '0;
            ncyc_q        <= '0;
            to_lim_q      <= '0;
            ph_cnt_q      <= '0;
            to_cnt_q      <= '0;
            det_reset_n_q <= 1'b0;
            det_enable_q  <= 1'b0;
            data_out_q    <= '0;
            acq_enable_q  <= 1'b0;
            sync_pulse_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptos_q        <= ptos_d;
            ncyc_q        <= ncyc_d;
            to_lim_q      <= to_lim_d;
            ph_cnt_q      <= ph_cnt_d;
            to_cnt_q      <= to_cnt_d;
            det_reset_n_q <= det_reset_n_d;
            det_enable_q  <= det_enable_d;
            data_out_q    <= data_in_i;
            acq_enable_q  <= acq_enable_d;
            sync_pulse_q  <= sync_pulse_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

    cycle_sample_counter #(
        .CNT_W (CNT_W)
    ) u_cycle_sample_counter (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .clear_i      (cnt_clear),
        .advance_i    (cnt_advance),
        .ptos_i       (ptos_q),
        .ncyc_i       (ncyc_q),
        .sample_idx_o (sample_idx_o),
        .cycle_idx_o  (cycle_idx_o),
        .terminal_o   (cnt_terminal)
    );

    assign det_reset_n_o = det_reset_n_q;
    assign det_enable_o  = det_enable_q;
    assign det_ptos_o    = ptos_q;
    assign data_out_o    = data_out_q;
    assign acq_enable_o  = acq_enable_q;
    assign sync_pulse_o  = sync_pulse_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign timeout_err_o = timeout_err_q;
    assign cfg_err_o     = cfg_err_q;

endmodule : zero_cross_sync_ctrl

// File: tb/tb_zero_cross_sync_ctrl.sv
// -----------------------------------------------------------------------------
// tb_zero_cross_sync_ctrl
// Directed bench for zero_cross_sync_ctrl. Inputs change on the falling edge,
// outputs are checked on the falling edge. A minimal detector stand-in raises
// zero_cross on phase 0 of a 16-point sine once the detector has been enabled
// for two full periods (learning window plus one tracking period).
// -----------------------------------------------------------------------------
module tb_zero_cross_sync_ctrl;

    localparam int DATA_W = 14;
    localparam int CNT_W  = 16;
    localparam int TO_W   = 24;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic              abort;
    logic [CNT_W-1:0]  ptos;
    logic [CNT_W-1:0]  n_ciclos;
    logic [TO_W-1:0]   timeout;
    logic [DATA_W-1:0] data_in;
    logic              zero_cross;
    logic              det_reset_n;
    logic              det_enable;
    logic [CNT_W-1:0]  det_ptos;
    logic [DATA_W-1:0] data_out;
    logic              acq_enable;
    logic [CNT_W-1:0]  sample_idx;
    logic [CNT_W-1:0]  cycle_idx;
    logic              sync_pulse;
    logic              busy;
    logic              done;
    logic              timeout_err;
    logic              cfg_err;

    int n_checks = 0;
    int n_fail   = 0;

    // 8192 + round(4000*sin(2*pi*k/16))
    int sine_tab [16] = '{8192, 9723, 11020, 11888, 12192, 11888, 11020, 9723,
                          8192, 6661, 5364, 4496, 4192, 4496, 5364, 6661};
    int phase     = 0;
    int cur_phase = 1;
    int en_cnt    = 0;
    logic sine_on  = 1'b0;
    logic model_on = 1'b0;

    always #5 clk = ~clk;

    zero_cross_sync_ctrl #(
        .DATA_W       (DATA_W),
        .CNT_W        (CNT_W),
        .TO_W         (TO_W),
        .CLEAR_CYCLES (2)
    ) dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .start_i        (start),
        .abort_i        (abort),
        .ptos_x_ciclo_i (ptos),
        .n_ciclos_i     (n_ciclos),
        .timeout_ptos_i (timeout),
        .data_in_i      (data_in),
        .zero_cross_i   (zero_cross),
        .det_reset_n_o  (det_reset_n),
        .det_enable_o   (det_enable),
        .det_ptos_o     (det_ptos),
        .data_out_o     (data_out),
        .acq_enable_o   (acq_enable),
        .sample_idx_o   (sample_idx),
        .cycle_idx_o    (cycle_idx),
        .sync_pulse_o   (sync_pulse),
        .busy_o         (busy),
        .done_o         (done),
        .timeout_err_o  (timeout_err),
        .cfg_err_o      (cfg_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; then present the next sample and detector output.
    task automatic cyc();
        @(negedge clk);
        if (sine_on) begin
            cur_phase = phase;
            data_in   = DATA_W'(sine_tab[phase]);
            phase     = (phase + 1) % 16;
        end
        if (!det_reset_n) en_cnt = 0;
        zero_cross = model_on && det_enable && (en_cnt >= 2 * int'(det_ptos)) && (cur_phase == 0);
        if (det_enable) en_cnt++;
    endtask

    task automatic pulse_start(input int p, input int n, input int t);
        ptos     = CNT_W'(p);
        n_ciclos = CNT_W'(n);
        timeout  = TO_W'(t);
        start    = 1'b1;
        cyc();
        start    = 1'b0;
    endtask

    task automatic wait_zc(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (zero_cross) break;
            cyc();
        end
        chk(tag, zero_cross, 1'b1);
    endtask

    initial begin
        logic seen;
        reset_n    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        ptos       = '0;
        n_ciclos   = '0;
        timeout    = '0;
        data_in    = '0;
        zero_cross = 1'b0;

        // ---- reset state
        repeat (2) @(negedge clk);
        chk("rst_det_reset_n", det_reset_n, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_data_out", data_out, 14'd0);
        reset_n = 1'b1;
        cyc();
        chk("idle_det_reset_n", det_reset_n, 1'b1);
        chk("idle_busy", busy, 1'b0);

        // ---- 1: sine, ptos=16, n=3, timeout=64
        sine_on  = 1'b1;
        model_on = 1'b1;
        pulse_start(16, 3, 64);
        chk("t1_busy", busy, 1'b1);
        chk("t1_clear_det_reset_n", det_reset_n, 1'b0);
        chk("t1_det_ptos", det_ptos, 16'd16);
        wait_zc("t1_zc_found");
        chk("t1_search_acq", acq_enable, 1'b0);
        chk("t1_search_det_en", det_enable, 1'b1);
        cyc();
        chk("t1_sync", sync_pulse, 1'b1);
        chk("t1_sync_acq", acq_enable, 1'b1);
        chk("t1_sync_data", data_out, 14'd8192);
        chk("t1_sync_sidx", sample_idx, 16'd0);
        chk("t1_sync_cidx", cycle_idx, 16'd0);
        for (int k = 1; k < 48; k++) begin
            cyc();
            chk("t1_acq", acq_enable, 1'b1);
            chk("t1_sync_low", sync_pulse, 1'b0);
            chk("t1_sidx", sample_idx, 32'(k % 16));
            chk("t1_cidx", cycle_idx, 32'(k / 16));
            chk("t1_data", data_out, 32'(sine_tab[k % 16]));
        end
        cyc();
        chk("t1_end_acq", acq_enable, 1'b0);
        chk("t1_done", done, 1'b1);
        chk("t1_done_det_en", det_enable, 1'b0);
        cyc();
        chk("t1_done_low", done, 1'b0);
        chk("t1_idle_busy", busy, 1'b0);

        // ---- 2: constant input, timeout after 40 SEARCH samples
        sine_on  = 1'b0;
        model_on = 1'b0;
        data_in  = 14'd5000;
        pulse_start(16, 1, 40);
        chk("t2_clear1", det_reset_n, 1'b0);
        cyc();
        chk("t2_clear2", det_reset_n, 1'b0);
        cyc();
        chk("t2_learn_det_reset_n", det_reset_n, 1'b1);
        chk("t2_learn_det_en", det_enable, 1'b1);
        seen = 1'b0;
        repeat (55) begin
            cyc();
            if (acq_enable) seen = 1'b1;
        end
        chk("t2_last_search_busy", busy, 1'b1);
        chk("t2_last_search_to", timeout_err, 1'b0);
        cyc();
        chk("t2_timeout_err", timeout_err, 1'b1);
        chk("t2_busy", busy, 1'b0);
        chk("t2_det_en", det_enable, 1'b0);
        chk("t2_acq_never", seen, 1'b0);

        // ---- 3: bad configuration and start+abort in IDLE
        pulse_start(1, 3, 64);
        chk("t3_cfg_err", cfg_err, 1'b1);
        chk("t3_busy", busy, 1'b0);
        chk("t3_det_reset_n", det_reset_n, 1'b1);
        chk("t3_to_sticky", timeout_err, 1'b1);
        cyc();
        chk("t3_cfg_err_low", cfg_err, 1'b0);
        pulse_start(8, 3, 0);
        chk("t3_cfg_err_to0", cfg_err, 1'b1);
        abort = 1'b1;
        pulse_start(8, 3, 64);
        abort = 1'b0;
        chk("t3_abort_start_busy", busy, 1'b0);
        chk("t3_abort_start_cfg", cfg_err, 1'b0);

        // ---- 4: abort on 10th ACQ clock, ptos=8, n=4
        sine_on  = 1'b1;
        model_on = 1'b1;
        pulse_start(8, 4, 64);
        chk("t4_to_cleared", timeout_err, 1'b0);
        wait_zc("t4_zc_found");
        cyc();
        chk("t4_sync", sync_pulse, 1'b1);
        repeat (9) cyc();
        chk("t4_acq10", acq_enable, 1'b1);
        chk("t4_sidx10", sample_idx, 16'd1);
        chk("t4_cidx10", cycle_idx, 16'd1);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("t4_abort_acq", acq_enable, 1'b0);
        chk("t4_abort_det_en", det_enable, 1'b0);
        chk("t4_abort_busy", busy, 1'b0);
        chk("t4_abort_done", done, 1'b0);
        cyc();
        chk("t4_no_done", done, 1'b0);

        // ---- 5: n_ciclos=0
        pulse_start(8, 0, 64);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (zero_cross) break;
            cyc();
            if (sync_pulse || acq_enable) seen = 1'b1;
        end
        chk("t5_zc_found", zero_cross, 1'b1);
        cyc();
        chk("t5_done", done, 1'b1);
        chk("t5_sync", sync_pulse, 1'b0);
        chk("t5_acq", acq_enable, 1'b0);
        chk("t5_never", seen, 1'b0);
        cyc();
        chk("t5_done_low", done, 1'b0);
        chk("t5_busy", busy, 1'b0);

        // ---- 6: asynchronous reset during LEARN
        pulse_start(16, 1, 64);
        repeat (5) cyc();
        chk("t6_in_learn", det_enable, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_det_reset_n", det_reset_n, 1'b0);
        chk("t6_rst_det_en", det_enable, 1'b0);
        chk("t6_rst_det_ptos", det_ptos, 16'd0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_data_out", data_out, 14'd0);
        chk("t6_rst_sidx", sample_idx, 16'd0);
        chk("t6_rst_cidx", cycle_idx, 16'd0);
        cyc();
        chk("t6_rst_hold_busy", busy, 1'b0);
        reset_n = 1'b1;
        cyc();
        chk("t6_rel_det_reset_n", det_reset_n, 1'b1);
        pulse_start(16, 1, 64);
        chk("t6_restart_busy", busy, 1'b1);
        chk("t6_restart_clear", det_reset_n, 1'b0);
        chk("t6_restart_ptos", det_ptos, 16'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_zero_cross_sync_ctrl

// File: doc/zero_cross_sync_ctrl.md
Name: zero_cross_sync_ctrl

Overview:
- Sequencer that owns the optimal zero-cross detector (measure_zero_cross_optimo) and gates a downstream per-cycle acquisition, such as a lock-in or averager, so that it starts exactly on a detected positive-slope crossing.
- Clears the detector, feeds it one learning period, waits for its zero_cross pulse, then streams N whole signal cycles of aligned data downstream.
- Handles timeout, abort and invalid configuration.

Parameters:
- DATA_W, 14, sample width (matches detector data).
- CNT_W, 16, width of ptos_x_ciclo, n_ciclos and the per-cycle sample counters.
- TO_W, 24, width of the timeout sample counter.
- CLEAR_CYCLES, 2, clocks det_reset_n is held low before learning starts.

Ports:
- clk  in  1  system clock; one sample per clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-clock request; honoured only in IDLE.
- abort  in  1  returns the block to IDLE from any state.
- ptos_x_ciclo  in  CNT_W  samples per signal cycle; latched on start.
- n_ciclos  in  CNT_W  whole cycles to acquire; latched on start.
- timeout_ptos  in  TO_W  maximum samples spent in SEARCH; latched on start.
- data_in  in  DATA_W  raw sample; also wired to the detector.
- zero_cross  in  1  detector output (combinational on its side).
- det_reset_n  out  1  detector reset; reset value 0.
- det_enable  out  1  detector enable; reset value 0.
- det_ptos  out  CNT_W  latched ptos_x_ciclo to the detector; reset value 0.
- data_out  out  DATA_W  data_in delayed 1 clock; reset value 0.
- acq_enable  out  1  data_out belongs to the acquisition window; reset value 0.
- sample_idx  out  CNT_W  index of data_out within its cycle; reset value 0.
- cycle_idx  out  CNT_W  cycle number of data_out; reset value 0.
- sync_pulse  out  1  one clock, aligned with sample_idx=0, cycle_idx=0; reset value 0.
- busy  out  1  high in any state other than IDLE; reset value 0.
- done  out  1  one-clock pulse on normal completion; reset value 0.
- timeout_err  out  1  sticky flag, cleared by the next accepted start; reset value 0.
- cfg_err  out  1  one-clock pulse when start is rejected for bad configuration; reset value 0.

Behaviour:
- All outputs are registered. det_reset_n is 1 in every state except CLEAR.
- States and transitions:
  - IDLE: on start with ptos_x_ciclo<2 or timeout_ptos=0, pulse cfg_err and stay. On a valid start, latch the configuration, clear timeout_err, go to CLEAR.
  - CLEAR: det_reset_n=0 and det_enable=0 for CLEAR_CYCLES clocks, then go to LEARN.
  - LEARN: det_enable=1 for exactly ptos_x_ciclo clocks. This is the detector's max/min window. Then go to SEARCH.
  - SEARCH: det_enable=1 and the timeout counter increments every clock.
    - When zero_cross=1, go to ACQ. The next clock shows data_out equal to the crossing sample, with acq_enable=1, sync_pulse=1, sample_idx=0 and cycle_idx=0.
    - If the counter reaches timeout_ptos with no crossing, set timeout_err, clear det_enable and go to IDLE.
    - The detector needs one more full period to set posicion_ready, so a timeout_ptos below 2*ptos_x_ciclo is expected to time out.
  - ACQ: acq_enable=1 every clock.
    - sample_idx wraps from ptos_x_ciclo-1 to 0 and cycle_idx increments on that wrap.
    - After the sample with cycle_idx=n_ciclos-1 and sample_idx=ptos_x_ciclo-1, drop acq_enable on the following clock and go to DONE.
    - zero_cross pulses during ACQ are ignored.
  - DONE: pulse done, clear det_enable, go to IDLE.
- n_ciclos=0: the sync_pulse/acq_enable clock is suppressed. SEARCH goes straight to DONE on zero_cross, and done fires 1 clock later.
- Simultaneous events:
  - abort has priority over everything, including zero_cross, a timeout in the same clock, and start.
  - abort takes effect next clock: IDLE, det_enable=0, acq_enable=0, no done, no timeout_err.
  - A start while busy is ignored. A start together with abort in IDLE is ignored.
- Counters use unsigned compares at CNT_W/TO_W width. Configuration changes while busy have no effect.
- reset_n asserted mid-operation returns every output to its reset value immediately (asynchronous). This includes det_reset_n=0, which also clears the detector.

Decomposition:
- Shared package (zero_cross_pkg): state encoding constants (IDLE, CLEAR, LEARN, SEARCH, ACQ, DONE), DATA_W/CNT_W defaults, and the minimum ptos_x_ciclo constant (2).
- One natural sub-module: cycle_sample_counter (sample_idx/cycle_idx wrap counter with terminal flag), reused by the downstream averagers.
- The detector is instantiated by the parent, not inside this block.

Test Plan:
- ptos=16, n_ciclos=3, timeout=64, 16-point sine offset 8192, amplitude 4000, from the detector model -> sync_pulse where data_out is the first positive-slope sample nearest 8192; 48 clocks of acq_enable; cycle_idx runs 0..2; done 1 clock after the last sample.
- Constant data_in=5000, ptos=16, timeout=40 -> no zero_cross; timeout_err set 40 clocks after SEARCH entry; acq_enable never high; busy low next clock.
- start with ptos_x_ciclo=1 -> cfg_err pulse; busy stays 0; det_reset_n stays 1.
- abort asserted on the 10th clock of ACQ (ptos=8, n=4) -> next clock: acq_enable=0, det_enable=0, busy=0; no done.
- n_ciclos=0, ptos=8 -> done 1 clock after zero_cross; sync_pulse and acq_enable never high.
- reset_n pulsed low during LEARN -> all outputs at reset values asynchronously; a new start is accepted after release.
